digest_serializer: RTL and testbench

Output-side counterpart of the input padder. It accepts a 512-bit digest from the `f_permutation` module and captures it with a one-cycle handshake. It then streams the digest to the user as 64-bit words under a valid/ack handshake, most significant word first. It sits between `f_permutation` and the user module and is the only path by which hash results leave the core.

---
 rtl/sha3_pkg.sv | 15 +
 rtl/digest_serializer_if.sv | 25 ++
 rtl/byte_swap64.sv | 11 +
 rtl/digest_serializer.sv | 75 +++++++
 tb/tb_digest_serializer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha3_pkg.sv
// Shared widths, serializer state encoding and the legal NUM_WORDS range
// used by the digest output path.
package sha3_pkg;

    localparam int DIGEST_W      = 512;
    localparam int WORD_W        = 64;
    localparam int MIN_NUM_WORDS = 1;
    localparam int MAX_NUM_WORDS = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/digest_serializer_if.sv
// Digest capture port (from f_permutation) and word stream port (to the user).
// Handshakes: a digest moves when in_ready and in_ack are both high; a word moves when out_valid and out_ack are both high.
interface digest_serializer_if;
    import sha3_pkg::*;

    logic [DIGEST_W-1:0] in;
    logic                in_ready;
    logic                in_ack;
    logic [WORD_W-1:0]   out;
    logic                out_valid;
    logic                out_ack;
    logic                out_last;
    logic                busy;

    modport slave (
        input  in, in_ready, out_ack,
        output in_ack, out, out_valid, out_last, busy
    );

    modport master (
        output in, in_ready, out_ack,
        input  in_ack, out, out_valid, out_last, busy
    );

endinterface

// File: rtl/byte_swap64.sv
// Reverses the byte order of a 64-bit word (Keccak lane little-endian view).
module byte_swap64 (
    input  logic [63:0] data_i,
    output logic [63:0] data_o
);

    for (genvar i = 0; i < 8; i++) begin : g_byte
        assign data_o[8*i +: 8] = data_i[8*(7-i) +: 8];
    end

endmodule

// File: rtl/digest_serializer.sv
// Captures a 512-bit digest and streams its top NUM_WORDS 64-bit words, MSW first.
// Optional feature macro DIGEST_BYTE_SWAP_EN: present each word byte-reversed.
module digest_serializer
    import sha3_pkg::*;
#(
    parameter int NUM_WORDS = 8
) (
    input  logic                clk,
    input  logic                reset,
    digest_serializer_if.slave  bus,
    output ser_state_t          dbg_state_o,
    output logic [2:0]          dbg_cnt_o
);

    if (NUM_WORDS < MIN_NUM_WORDS || NUM_WORDS > MAX_NUM_WORDS) begin : g_bad_num_words
        $error("digest_serializer: NUM_WORDS must be in 1..8");
    end

    localparam logic [2:0] LAST_CNT = 3'(NUM_WORDS - 1);

    ser_state_t          state_q;
    logic [DIGEST_W-1:0] buf_q;
    logic [2:0]          cnt_q;
    logic [WORD_W-1:0]   head;
    logic [WORD_W-1:0]   out_word;
    logic                out_valid;
    logic                hs;
    logic                fin;
    logic                load;

    assign out_valid = (state_q == SEND);
    assign hs        = out_valid & bus.out_ack;
    assign fin       = hs & (cnt_q == LAST_CNT);
    // A fin cycle may accept the next digest, giving zero-bubble reloads.
    assign load      = reset & bus.in_ready & ((state_q == IDLE) | fin);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            state_q <= SEND;
            buf_q   <= bus.in;
            cnt_q   <= '0;
        end else if (fin) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (hs) begin
            buf_q   <= {buf_q[DIGEST_W-WORD_W-1:0], {WORD_W{1'b0}}};
            cnt_q   <= cnt_q + 3'd1;
        end
    end

    assign head = buf_q[DIGEST_W-1 -: WORD_W];

`ifdef DIGEST_BYTE_SWAP_EN
    byte_swap64 u_byte_swap (
        .data_i (head),
        .data_o (out_word)
    );
`else
    assign out_word = head;
`endif

    assign bus.out       = out_word;
    assign bus.out_valid = out_valid;
    assign bus.busy      = out_valid;
    assign bus.out_last  = out_valid & (cnt_q == LAST_CNT);
    assign bus.in_ack    = load;

    assign dbg_state_o = state_q;
    assign dbg_cnt_o   = cnt_q;

endmodule

// File: tb/tb_digest_serializer.sv
// Bench for digest_serializer: an 8-word instance and a 4-word truncating instance.
module tb_digest_serializer;
  import sha3_pkg::*;

  logic       clk;
  logic       reset;
  logic       ack_dir8;
  logic       ack_dir4;
  logic       ack_rnd;
  logic       rand_en;
  ser_state_t st8, st4;
  logic [2:0] cnt8, cnt4;

  int n_total  = 0;
  int n_bad    = 0;
  int n_sent8  = 0;
  int ack_cnt8 = 0;

  logic [64:0] exp_q[$];
  logic [64:0] exp4_q[$];

  digest_serializer_if bus8 ();
  digest_serializer_if bus4 ();

  digest_serializer #(.NUM_WORDS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus8.slave),
    .dbg_state_o (st8),
    .dbg_cnt_o   (cnt8)
  );

  digest_serializer #(.NUM_WORDS(4)) dut4 (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus4.slave),
    .dbg_state_o (st4),
    .dbg_cnt_o   (cnt4)
  );

  assign bus8.out_ack = rand_en ? ack_rnd : ack_dir8;
  assign bus4.out_ack = ack_dir4;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    ack_rnd = 1'($urandom_range(0, 1));
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_word(input logic [63:0] w);
    logic [63:0] r;
`ifdef DIGEST_BYTE_SWAP_EN
    for (int i = 0; i < 8; i++) r[8*i +: 8] = w[8*(7-i) +: 8];
`else
    r = w;
`endif
    return r;
  endfunction

  function automatic logic [511:0] make_digest(input int base);
    logic [511:0] d;
    for (int k = 0; k < 8; k++) d[511-64*k -: 64] = 64'(base + k);
    return d;
  endfunction

  task automatic push_words(input bit sel, input logic [511:0] d);
    int n;
    n = sel ? 4 : 8;
    for (int k = 0; k < n; k++) begin
      if (sel) exp4_q.push_back({(k == n-1), exp_word(d[511-64*k -: 64])});
      else     exp_q.push_back({(k == n-1), exp_word(d[511-64*k -: 64])});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_digest(input bit sel, input logic [511:0] d);
    bit got;
    got = 1'b0;
    if (sel) begin bus4.in = d; bus4.in_ready = 1'b1; end
    else     begin bus8.in = d; bus8.in_ready = 1'b1; n_sent8++; end
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (sel ? bus4.in_ack : bus8.in_ack) got = 1'b1;
    end
    check(sel ? "cap4" : "cap8", got, 1);
    if (got) push_words(sel, d);
    @(posedge clk);
    #1;
    if (sel) bus4.in_ready = 1'b0;
    else     bus8.in_ready = 1'b0;
  endtask

  task automatic wait_idle(input bit sel, input string tag);
    logic b;
    b = 1'b1;
    for (int i = 0; i < 500 && b; i++) begin
      @(negedge clk);
      b = sel ? bus4.busy : bus8.busy;
    end
    check(tag, b, 0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [64:0] e;
    if (reset && bus8.out_valid && bus8.out_ack) begin
      if (exp_q.size() == 0) check("sb8_extra", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        check("sb8_word", {bus8.out_last, bus8.out}, e);
      end
    end
    if (reset && bus8.in_ack) ack_cnt8++;
  end

  always @(negedge clk) begin
    logic [64:0] e;
    if (reset && bus4.out_valid && bus4.out_ack) begin
      if (exp4_q.size() == 0) check("sb4_extra", exp4_q.size(), 1);
      else begin
        e = exp4_q.pop_front();
        check("sb4_word", {bus4.out_last, bus4.out}, e);
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [511:0] d;
    bit           seen;

    reset         = 1'b0;
    rand_en       = 1'b0;
    ack_dir8      = 1'b0;
    ack_dir4      = 1'b0;
    bus8.in       = '0;
    bus4.in       = '0;
    bus8.in_ready = 1'b1;
    bus4.in_ready = 1'b0;

    // Reset state, with in_ready high to show in_ack is held off.
    repeat (2) @(negedge clk);
    check("rst_in_ack", bus8.in_ack, 0);
    check("rst_valid",  bus8.out_valid, 0);
    check("rst_out",    bus8.out, 0);
    check("rst_last",   bus8.out_last, 0);
    check("rst_busy",   bus8.busy, 0);
    check("rst_state",  st8, IDLE);
    check("rst_cnt",    cnt8, 0);
    check("rst_busy4",  bus4.busy, 0);
    check("rst_cnt4",   cnt4, 0);
    bus8.in_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Basic digest, out_ack tied high.
    @(posedge clk); #1;
    ack_dir8 = 1'b1;
    send_digest(0, make_digest(1));
    repeat (8) @(negedge clk);
    @(negedge clk);
    check("basic_busy_drop", bus8.busy, 0);
    check("basic_state", st8, IDLE);

    // Back-pressure on word 3.
    @(posedge clk); #1;
    send_digest(0, make_digest(32'h11));
    @(posedge clk); #1;
    @(posedge clk); #1;
    ack_dir8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out",   bus8.out, exp_word(64'h13));
      check("bp_cnt",   cnt8, 2);
      check("bp_valid", bus8.out_valid, 1);
      check("bp_last",  bus8.out_last, 0);
      @(posedge clk); #1;
    end
    ack_dir8 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_next", bus8.out, exp_word(64'h14));
    wait_idle(0, "bp_idle");

    // Back-to-back: second digest pending from mid-first-digest.
    @(posedge clk); #1;
    send_digest(0, make_digest(1));
    repeat (3) @(posedge clk);
    #1;
    bus8.in       = make_digest(9);
    bus8.in_ready = 1'b1;
    n_sent8++;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      check("b2b_ack", bus8.in_ack, bus8.out_last);
      if (bus8.in_ack) begin
        seen = 1'b1;
        push_words(0, make_digest(9));
      end
    end
    check("b2b_cap", seen, 1);
    @(posedge clk); #1;
    bus8.in_ready = 1'b0;
    @(negedge clk);
    check("b2b_next_valid", bus8.out_valid, 1);
    check("b2b_next_word",  bus8.out, exp_word(64'h9));
    check("b2b_next_cnt",   cnt8, 0);
    wait_idle(0, "b2b_idle");

    // Truncated digest on the NUM_WORDS=4 instance.
    @(posedge clk); #1;
    ack_dir4 = 1'b1;
    send_digest(1, make_digest(1));
    repeat (4) @(negedge clk);
    @(negedge clk);
    check("nw4_busy_drop", bus4.busy, 0);
    check("nw4_state", st4, IDLE);
    check("nw4_drain", exp4_q.size(), 0);

    // Reset after word 5.
    @(posedge clk); #1;
    send_digest(0, make_digest(32'h21));
    repeat (5) @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_valid",  bus8.out_valid, 0);
    check("mid_rst_busy",   bus8.busy, 0);
    check("mid_rst_out",    bus8.out, 0);
    check("mid_rst_last",   bus8.out_last, 0);
    check("mid_rst_in_ack", bus8.in_ack, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_valid", bus8.out_valid, 0);
    end

`ifdef DIGEST_BYTE_SWAP_EN
    // Byte-reversed presentation of the first word.
    @(posedge clk); #1;
    d = make_digest(1);
    d[511:448] = 64'h0102030405060708;
    send_digest(0, d);
    @(negedge clk);
    check("swap_out", bus8.out, 64'h0807060504030201);
    wait_idle(0, "swap_idle");
`endif

    // Random digests with random back-pressure, each queued while the previous streams.
    @(posedge clk); #1;
    rand_en = 1'b1;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 16; k++) d[32*k +: 32] = $urandom_range(32'hffff_ffff, 0);
      send_digest(0, d);
    end
    wait_idle(0, "rand_idle");
    rand_en = 1'b0;

    @(negedge clk);
    check("drain8", exp_q.size(), 0);
    check("ack_count", ack_cnt8, n_sent8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
